// File: rtl/daq_mode_switch.sv
// Routes one of NUM_MODES DAQ sources to the shared USB FIFO, Microroc SC and trigger lines.
// A mode change drains the old source, gates the outputs, writes a marker word and reloads SC params.
module daq_mode_switch #(
  parameter int          NUM_MODES   = 4,
  parameter int          MODE_W      = 2,
  parameter int          DATA_W      = 16,
  parameter int          CHN_W       = 64,
  parameter int          DAC_W       = 10,
  parameter int          QUIET_CYC   = 8,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [7:0]  MARKER_HI   = 8'hFA
) (
  input  logic                          Clk,
  input  logic                          reset_n,
  input  logic [MODE_W-1:0]             mode_sel,
  input  logic [NUM_MODES*DATA_W-1:0]   src_fifo_wr_din,
  input  logic [NUM_MODES-1:0]          src_fifo_wr_en,
  input  logic [NUM_MODES-1:0]          src_busy,
  input  logic [NUM_MODES*CHN_W-1:0]    src_ctest_chn,
  input  logic [NUM_MODES*DAC_W-1:0]    src_dac,
  input  logic [NUM_MODES-1:0]          src_sc_load,
  input  logic                          usb_fifo_full,
  input  logic [2:0]                    pin_trigger_b,
  output logic [DATA_W-1:0]             out_fifo_wr_din,
  output logic                          out_fifo_wr_en,
  output logic [CHN_W-1:0]              out_ctest_chn,
  output logic [DAC_W-1:0]              out_dac,
  output logic                          out_sc_load,
  output logic [NUM_MODES*3-1:0]        src_trigger_b,
  output logic [MODE_W-1:0]             active_mode,
  output logic                          switching,
  output logic                          switch_timeout,
  output logic                          invalid_mode,
  output logic [15:0]                   dropped_cnt
);

  typedef enum logic [2:0] {RUN, DRAIN, GATE, MARK, LOAD} state_t;

  localparam int QW = $clog2(QUIET_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = $clog2(NUM_MODES + 1);

  state_t              state;
  logic [MODE_W-1:0]   target;
  logic [QW-1:0]       quiet_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic                forced;

  int                  a_idx, t_idx;
  logic [DATA_W-1:0]   act_din, marker;
  logic                act_wr, act_busy, act_sc, mode_bad;
  logic [CHN_W-1:0]    act_chn, tgt_chn;
  logic [DAC_W-1:0]    act_dac, tgt_dac;
  logic [QW-1:0]       q_nxt;
  logic [TW-1:0]       t_nxt;
  logic [CW-1:0]       wr_pop;
  logic [16:0]         drop_sum;
  logic [NUM_MODES*3-1:0] trig_run;

  always_comb begin
    a_idx    = int'(active_mode);
    t_idx    = int'(target);
    act_din  = src_fifo_wr_din[a_idx*DATA_W +: DATA_W];
    act_wr   = src_fifo_wr_en[a_idx];
    act_busy = src_busy[a_idx];
    act_sc   = src_sc_load[a_idx];
    act_chn  = src_ctest_chn[a_idx*CHN_W +: CHN_W];
    act_dac  = src_dac[a_idx*DAC_W +: DAC_W];
    tgt_chn  = src_ctest_chn[t_idx*CHN_W +: CHN_W];
    tgt_dac  = src_dac[t_idx*DAC_W +: DAC_W];
    mode_bad = (32'(mode_sel) >= 32'(NUM_MODES));
    q_nxt    = (!act_busy && !act_wr) ? quiet_cnt + 1'b1 : '0;
    t_nxt    = tmo_cnt + 1'b1;
    marker   = {MARKER_HI, {(DATA_W-8-MODE_W){1'b0}}, target};
    // every strobe seen while the outputs are gated is one lost word
    wr_pop   = '0;
    for (int i = 0; i < NUM_MODES; i++) wr_pop = wr_pop + CW'(src_fifo_wr_en[i]);
    drop_sum = {1'b0, dropped_cnt} + 17'(wr_pop);
    trig_run = '1;
    trig_run[a_idx*3 +: 3] = pin_trigger_b;
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state           <= RUN;
      target          <= '0;
      quiet_cnt       <= '0;
      tmo_cnt         <= '0;
      forced          <= 1'b0;
      out_fifo_wr_din <= '0;
      out_fifo_wr_en  <= 1'b0;
      out_ctest_chn   <= '0;
      out_dac         <= '0;
      out_sc_load     <= 1'b0;
      src_trigger_b   <= '1;
      active_mode     <= '0;
      switching       <= 1'b0;
      switch_timeout  <= 1'b0;
      invalid_mode    <= 1'b0;
      dropped_cnt     <= '0;
    end else begin
      invalid_mode <= 1'b0;
      if (state == GATE || state == MARK || state == LOAD)
        dropped_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      case (state)
        RUN, DRAIN: begin
          out_fifo_wr_din <= act_din;
          out_fifo_wr_en  <= act_wr;
          out_ctest_chn   <= act_chn;
          out_dac         <= act_dac;
          out_sc_load     <= act_sc;
          src_trigger_b   <= trig_run;
          if (state == RUN) begin
            if (mode_bad) begin
              invalid_mode <= 1'b1;
            end else if (mode_sel != active_mode) begin
              target    <= mode_sel;
              quiet_cnt <= '0;
              tmo_cnt   <= '0;
              state     <= DRAIN;
              switching <= 1'b1;
            end
          end else begin
            quiet_cnt <= q_nxt;
            tmo_cnt   <= t_nxt;
            if (q_nxt == QW'(QUIET_CYC)) begin
              forced <= 1'b0;
              state  <= GATE;
            end else if (t_nxt == TW'(TIMEOUT_CYC)) begin
              forced         <= 1'b1;
              switch_timeout <= 1'b1;
              state          <= GATE;
            end
          end
        end
        GATE: begin
          out_fifo_wr_en <= 1'b0;
          out_sc_load    <= 1'b0;
          src_trigger_b  <= '1;
          state          <= MARK;
        end
        MARK: begin
          out_sc_load   <= 1'b0;
          src_trigger_b <= '1;
          // the marker is only issued on a cycle the FIFO reports room
          out_fifo_wr_en <= !usb_fifo_full;
          if (!usb_fifo_full) begin
            out_fifo_wr_din <= marker;
            state           <= LOAD;
          end
        end
        LOAD: begin
          out_fifo_wr_en <= 1'b0;
          out_ctest_chn  <= tgt_chn;
          out_dac        <= tgt_dac;
          out_sc_load    <= 1'b1;
          src_trigger_b  <= '1;
          active_mode    <= target;
          if (!forced) switch_timeout <= 1'b0;
          switching      <= 1'b0;
          state          <= RUN;
        end
        default: begin
          state     <= RUN;
          switching <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_daq_mode_switch.sv
// Directed bench for daq_mode_switch with three sources (mode 3 exercises the invalid-mode path).
module tb_daq_mode_switch;
  localparam int NM = 3;
  localparam int MW = 2;

  logic               Clk = 1'b0;
  logic               reset_n;
  logic [MW-1:0]      mode_sel;
  logic [NM*16-1:0]   src_fifo_wr_din;
  logic [NM-1:0]      src_fifo_wr_en, src_busy, src_sc_load;
  logic [NM*64-1:0]   src_ctest_chn;
  logic [NM*10-1:0]   src_dac;
  logic               usb_fifo_full;
  logic [2:0]         pin_trigger_b;
  logic [15:0]        out_fifo_wr_din;
  logic               out_fifo_wr_en;
  logic [63:0]        out_ctest_chn;
  logic [9:0]         out_dac;
  logic               out_sc_load;
  logic [NM*3-1:0]    src_trigger_b;
  logic [MW-1:0]      active_mode;
  logic               switching, switch_timeout, invalid_mode;
  logic [15:0]        dropped_cnt;

  int total = 0;
  int bad   = 0;

  daq_mode_switch #(.NUM_MODES(NM), .MODE_W(MW)) dut (
    .Clk(Clk), .reset_n(reset_n), .mode_sel(mode_sel),
    .src_fifo_wr_din(src_fifo_wr_din), .src_fifo_wr_en(src_fifo_wr_en),
    .src_busy(src_busy), .src_ctest_chn(src_ctest_chn), .src_dac(src_dac),
    .src_sc_load(src_sc_load), .usb_fifo_full(usb_fifo_full),
    .pin_trigger_b(pin_trigger_b), .out_fifo_wr_din(out_fifo_wr_din),
    .out_fifo_wr_en(out_fifo_wr_en), .out_ctest_chn(out_ctest_chn),
    .out_dac(out_dac), .out_sc_load(out_sc_load), .src_trigger_b(src_trigger_b),
    .active_mode(active_mode), .switching(switching),
    .switch_timeout(switch_timeout), .invalid_mode(invalid_mode),
    .dropped_cnt(dropped_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    mode_sel        = '0;
    src_fifo_wr_din = '0;
    src_fifo_wr_en  = '0;
    src_busy        = '0;
    src_sc_load     = '0;
    src_ctest_chn   = {64'hC2, 64'hC1, 64'hC0};
    src_dac         = {10'h3, 10'h2, 10'h1};
    usb_fifo_full   = 1'b0;
    pin_trigger_b   = 3'b101;

    // reset state
    step(); step();
    chk("rst_wr_en", 64'(out_fifo_wr_en), 64'h0);
    chk("rst_trig", 64'(src_trigger_b), 64'h1FF);
    chk("rst_active", 64'(active_mode), 64'h0);
    chk("rst_switching", 64'(switching), 64'h0);
    chk("rst_dac", 64'(out_dac), 64'h0);
    chk("rst_dropped", 64'(dropped_cnt), 64'h0);

    // test 1: pass-through of source 0
    reset_n = 1'b1;
    src_fifo_wr_din[15:0] = 16'h000A;
    src_fifo_wr_en = 3'b001;
    step();
    chk("t1_din", 64'(out_fifo_wr_din), 64'h000A);
    chk("t1_wr_en", 64'(out_fifo_wr_en), 64'h1);
    chk("t1_trig", 64'(src_trigger_b), 64'h1FD);
    chk("t1_dac", 64'(out_dac), 64'h1);
    src_fifo_wr_en = 3'b010;
    step();
    chk("t1_nonact_wr", 64'(out_fifo_wr_en), 64'h0);
    chk("t1_nonact_drop", 64'(dropped_cnt), 64'h0);
    src_fifo_wr_en = '0;

    // test 2: quiet switch 0 -> 1
    mode_sel = 2'd1;
    step();
    chk("t2_switching", 64'(switching), 64'h1);
    chk("t2_active_old", 64'(active_mode), 64'h0);
    repeat (8) step();
    chk("t2_drain_trig", 64'(src_trigger_b), 64'h1FD);
    step();
    chk("t2_gate_wr", 64'(out_fifo_wr_en), 64'h0);
    chk("t2_gate_trig", 64'(src_trigger_b), 64'h1FF);
    step();
    chk("t2_marker", 64'(out_fifo_wr_din), 64'hFA01);
    chk("t2_marker_en", 64'(out_fifo_wr_en), 64'h1);
    step();
    chk("t2_load_sc", 64'(out_sc_load), 64'h1);
    chk("t2_load_dac", 64'(out_dac), 64'h2);
    chk("t2_load_chn", 64'(out_ctest_chn), 64'hC1);
    chk("t2_active", 64'(active_mode), 64'h1);
    chk("t2_done", 64'(switching), 64'h0);
    chk("t2_no_tmo", 64'(switch_timeout), 64'h0);
    step();
    chk("t2_run_trig", 64'(src_trigger_b), 64'h1EF);
    chk("t2_run_sc", 64'(out_sc_load), 64'h0);

    // test 5: writes during GATE/MARK are dropped and counted
    mode_sel = 2'd2;
    step();
    repeat (8) step();
    src_fifo_wr_din[31:16] = 16'h1234;
    src_fifo_wr_en = 3'b010;
    step();
    chk("t5_gate_wr", 64'(out_fifo_wr_en), 64'h0);
    chk("t5_drop1", 64'(dropped_cnt), 64'h1);
    step();
    chk("t5_marker", 64'(out_fifo_wr_din), 64'hFA02);
    chk("t5_drop2", 64'(dropped_cnt), 64'h2);
    src_fifo_wr_en = '0;
    step();
    chk("t5_active", 64'(active_mode), 64'h2);
    chk("t5_dac", 64'(out_dac), 64'h3);
    chk("t5_drop_hold", 64'(dropped_cnt), 64'h2);
    step();
    mode_sel = 2'd3;
    step();
    chk("t5_invalid", 64'(invalid_mode), 64'h1);
    chk("t5_inv_noswitch", 64'(switching), 64'h0);
    mode_sel = 2'd2;
    step();
    chk("t5_invalid_clr", 64'(invalid_mode), 64'h0);
    chk("t5_inv_active", 64'(active_mode), 64'h2);

    // test 3: forced switch with the old source stuck busy
    src_busy = 3'b100;
    mode_sel = 2'd0;
    step();
    for (int i = 0; i < 1023; i++) begin
      step();
      if (i == 0 || i == 1022) begin
        chk("t3_drain_sw", 64'(switching), 64'h1);
        chk("t3_drain_tmo", 64'(switch_timeout), 64'h0);
      end
    end
    step();
    chk("t3_tmo_set", 64'(switch_timeout), 64'h1);
    step();
    chk("t3_gate_wr", 64'(out_fifo_wr_en), 64'h0);
    step();
    chk("t3_marker", 64'(out_fifo_wr_din), 64'hFA00);
    chk("t3_marker_en", 64'(out_fifo_wr_en), 64'h1);
    step();
    chk("t3_active", 64'(active_mode), 64'h0);
    chk("t3_tmo_sticky", 64'(switch_timeout), 64'h1);
    chk("t3_dac", 64'(out_dac), 64'h1);
    src_busy = '0;
    step();

    // test 4: FIFO full stalls the marker
    mode_sel = 2'd1;
    step();
    repeat (8) step();
    usb_fifo_full = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_full_wr", 64'(out_fifo_wr_en), 64'h0);
      chk("t4_full_sw", 64'(switching), 64'h1);
    end
    usb_fifo_full = 1'b0;
    step();
    chk("t4_marker", 64'(out_fifo_wr_din), 64'hFA01);
    chk("t4_marker_en", 64'(out_fifo_wr_en), 64'h1);
    step();
    chk("t4_active", 64'(active_mode), 64'h1);
    chk("t4_tmo_clr", 64'(switch_timeout), 64'h0);
    chk("t4_sc", 64'(out_sc_load), 64'h1);
    step();

    // test 6: reset while in MARK
    mode_sel = 2'd2;
    step();
    repeat (8) step();
    step();
    reset_n = 1'b0;
    mode_sel = 2'd0;
    step();
    chk("t6_active", 64'(active_mode), 64'h0);
    chk("t6_switching", 64'(switching), 64'h0);
    chk("t6_no_marker", 64'(out_fifo_wr_en), 64'h0);
    chk("t6_dropped", 64'(dropped_cnt), 64'h0);
    reset_n = 1'b1;
    step();
    chk("t6_trig", 64'(src_trigger_b), 64'h1FD);
    chk("t6_run_wr", 64'(out_fifo_wr_en), 64'h0);
    chk("t6_run_sw", 64'(switching), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
